// File: rtl/bcd_display_seq.sv
// Sequential binary-to-7-segment driver: double-dabble one bit per clock,
// with overflow dash display and optional leading-zero blanking.
module bcd_display_seq #(
  parameter int IN_W     = 8,
  parameter int DIGITS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [8*DIGITS-1:0]   seg
);
  localparam int SW = 4*DIGITS;
  localparam int CW = $clog2(IN_W+1);
  localparam logic [63:0] MAXV = 64'(10**DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state, state_nx;

  logic [IN_W-1:0]         sh;
  logic [SW-1:0]           scr, scr_adj;
  logic [CW-1:0]           cnt;
  logic                    ovf_p;
  logic                    ovf_next;
  logic [DIGITS:0]         keep;
  logic [DIGITS-1:0][7:0]  seg_dec, seg_nx;

  // Wide compare folds to constant 0 when the display covers every input code.
  assign ovf_next = 64'(bin) > MAXV;
  assign busy     = (state != IDLE);
  assign keep[DIGITS] = 1'b0;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign scr_adj[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
    // keep[i]: this digit or one above it is non-zero; digit 0 always shown
    assign keep[i] = keep[i+1] | (scr[4*i +: 4] != 4'd0) | (i == 0);
    bcd_seg_dec u_dec (.digit(scr[4*i +: 4]), .seg(seg_dec[i]));
    assign seg_nx[i] = ovf_p                        ? 8'hBF :
                       (BLANK_LZ != 0 && !keep[i])  ? 8'hFF : seg_dec[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      scr   <= '0;
      cnt   <= '0;
      ovf_p <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      bcd   <= '0;
      seg   <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh    <= bin;
          scr   <= '0;
          cnt   <= CW'(IN_W);
          ovf_p <= ovf_next;
        end
        SHIFT: if (cnt != '0) begin
          // bits leaving the top digit are dropped; overflow came from the compare
          scr <= {scr_adj[SW-2:0], sh[IN_W-1]};
          sh  <= {sh[IN_W-2:0], 1'b0};
          cnt <= cnt - CW'(1);
        end
        LATCH: begin
          done <= 1'b1;
          ovf  <= ovf_p;
          bcd  <= ovf_p ? '1 : scr;
          seg  <= seg_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// Single BCD digit to active-low {dp,g,f,e,d,c,b,a}; non-decimal codes blank.
module bcd_seg_dec (
  input  logic [3:0] digit,
  output logic [7:0] seg
);
  always_comb begin
    seg = 8'hFF;
    case (digit)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  end
endmodule

// File: tb/tb_bcd_display_seq.sv
// Scoreboard bench: stimulus pushes hand-computed results, per-DUT monitors
// pop and compare on every done pulse.
module tb_bcd_display_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start2 = 1'b0;
  logic [7:0]  bin0 = '0;
  logic [9:0]  bin2 = '0;
  logic        busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
  logic [7:0]  bcd0, bcd1;
  logic [15:0] seg0, seg1;
  logic [11:0] bcd2;
  logic [23:0] seg2;

  bcd_display_seq #(.IN_W(8), .DIGITS(2), .BLANK_LZ(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .ovf(ovf0), .bcd(bcd0), .seg(seg0));
  bcd_display_seq #(.IN_W(8), .DIGITS(2), .BLANK_LZ(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bin(bin0),
    .busy(busy1), .done(done1), .ovf(ovf1), .bcd(bcd1), .seg(seg1));
  bcd_display_seq #(.IN_W(10), .DIGITS(3), .BLANK_LZ(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2), .seg(seg2));

  typedef struct {
    logic [11:0] bcd;
    logic [23:0] seg;
    logic        ovf;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon_cmp(input string tag, input bit has, input exp_t e,
                         input logic [11:0] b, input logic [23:0] s, input logic o);
    if (!has) begin
      checks++; errors++;
      $display("FAIL %s unexpected done got bcd %h seg %h", tag, b, s);
    end else begin
      chk({tag, "_bcd"}, 32'(b), 32'(e.bcd));
      chk({tag, "_seg"}, 32'(s), 32'(e.seg));
      chk({tag, "_ovf"}, 32'(o), 32'(e.ovf));
    end
  endtask

  exp_t ez = '{bcd: '0, seg: '0, ovf: 1'b0};

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) mon_cmp("d0", 1'b0, ez, 12'(bcd0), 24'(seg0), ovf0);
      else                mon_cmp("d0", 1'b1, q0.pop_front(), 12'(bcd0), 24'(seg0), ovf0);
    end
    if (done1) begin
      if (q1.size() == 0) mon_cmp("d1", 1'b0, ez, 12'(bcd1), 24'(seg1), ovf1);
      else                mon_cmp("d1", 1'b1, q1.pop_front(), 12'(bcd1), 24'(seg1), ovf1);
    end
    if (done2) begin
      if (q2.size() == 0) mon_cmp("d2", 1'b0, ez, bcd2, seg2, ovf2);
      else                mon_cmp("d2", 1'b1, q2.pop_front(), bcd2, seg2, ovf2);
    end
  end

  function automatic logic cur_done(input int w);
    return (w == 2) ? done2 : done0;
  endfunction
  function automatic logic cur_busy(input int w);
    return (w == 2) ? busy2 : busy0;
  endfunction
  function automatic logic [23:0] cur_seg(input int w);
    return (w == 2) ? seg2 : 24'(seg0);
  endfunction

  // Called #1 after an edge; pulses start across the next edge.
  task automatic issue0(input logic [7:0] b);
    bin0 = b; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask
  task automatic issue2(input logic [9:0] b);
    bin2 = b; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
  endtask

  task automatic push0(input logic [7:0] b, input logic [15:0] s0, input logic [15:0] s1,
                       input logic o);
    exp_t e;
    e.bcd = 12'(b); e.ovf = o;
    e.seg = 24'(s0); q0.push_back(e);
    e.seg = 24'(s1); q1.push_back(e);
  endtask
  task automatic push2(input logic [11:0] b, input logic [23:0] s, input logic o);
    exp_t e;
    e.bcd = b; e.seg = s; e.ovf = o;
    q2.push_back(e);
  endtask

  // Counts remaining edges to done, busy cycles, and any output change meanwhile.
  task automatic wait_done(input int w, input int exp_lat, input string tag);
    int lat = 0, bcnt = 0, hold_bad = 0;
    logic [23:0] s_hold = cur_seg(w);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (cur_busy(w)) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (cur_done(w)) begin seen = 1; break; end
      if (cur_seg(w) !== s_hold) hold_bad++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout no done within 40 cycles", tag);
    end else begin
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
      chk({tag, "_busy_low"}, 32'(cur_busy(w)), 32'd0);
      chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
    end
  endtask

  logic [7:0]  vb  [11] = '{8'd57, 8'd7, 8'd0, 8'd99, 8'd100, 8'd255, 8'd42, 8'd13, 8'd88, 8'd21, 8'd10};
  logic [7:0]  vbc [11] = '{8'h57, 8'h07, 8'h00, 8'h99, 8'hFF, 8'hFF, 8'h42, 8'h13, 8'h88, 8'h21, 8'h10};
  logic [15:0] vs0 [11] = '{16'h92F8, 16'hFFF8, 16'hFFC0, 16'h9090, 16'hBFBF, 16'hBFBF,
                            16'h99A4, 16'hF9B0, 16'h8080, 16'hA4F9, 16'hF9C0};
  logic [15:0] vs1 [11] = '{16'h92F8, 16'hC0F8, 16'hC0C0, 16'h9090, 16'hBFBF, 16'hBFBF,
                            16'h99A4, 16'hF9B0, 16'h8080, 16'hA4F9, 16'hF9C0};
  logic        vo  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int nd;
    #12;
    chk("rst_seg0", 32'(seg0), 32'h0000FFFF);
    chk("rst_bcd0", 32'(bcd0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_ovf0", 32'(ovf0), 32'h0);
    chk("rst_seg1", 32'(seg1), 32'h0000FFFF);
    chk("rst_seg2", 32'(seg2), 32'h00FFFFFF);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_seg0", 32'(seg0), 32'h0000FFFF);
    chk("idle_busy0", 32'(busy0), 32'h0);

    for (int i = 0; i < 11; i++) begin
      issue0(vb[i]);
      push0(vbc[i], vs0[i], vs1[i], vo[i]);
      wait_done(0, 10, "vec");
      repeat (2) @(posedge clk);
      #1;
    end

    // start while busy is ignored
    issue0(8'd42);
    push0(8'h42, 16'h99A4, 16'h99A4, 1'b0);
    repeat (2) @(posedge clk);
    #1 bin0 = 8'd13; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_done(0, 7, "ign");

    // back-to-back: start while done is high
    issue0(8'd13);
    push0(8'h13, 16'hF9B0, 16'hF9B0, 1'b0);
    wait_done(0, 10, "b2b");

    // bin changes mid-conversion
    repeat (2) @(posedge clk);
    #1;
    issue0(8'd57);
    push0(8'h57, 16'h92F8, 16'h92F8, 1'b0);
    repeat (4) @(posedge clk);
    #1 bin0 = 8'd3;
    wait_done(0, 6, "binchg");

    // reset mid-operation
    repeat (2) @(posedge clk);
    #1;
    issue0(8'd88);
    push0(8'h88, 16'h8080, 16'h8080, 1'b0);
    wait_done(0, 10, "pre_rst");
    repeat (2) @(posedge clk);
    #1;
    issue0(8'd21);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_bcd0", 32'(bcd0), 32'h0);
    chk("mrst_seg0", 32'(seg0), 32'h0000FFFF);
    chk("mrst_busy0", 32'(busy0), 32'h0);
    chk("mrst_done0", 32'(done0), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    repeat (14) @(negedge clk) if (done0) nd++;
    chk("mrst_no_done", 32'(nd), 32'h0);
    @(posedge clk); #1;
    issue0(8'd21);
    push0(8'h21, 16'hA4F9, 16'hA4F9, 1'b0);
    wait_done(0, 10, "post_rst");

    // 10-bit, 3-digit instance
    repeat (2) @(posedge clk);
    #1;
    issue2(10'd1023);
    push2(12'hFFF, 24'hBFBFBF, 1'b1);
    wait_done(2, 12, "w10_1023");
    repeat (2) @(posedge clk);
    #1;
    issue2(10'd999);
    push2(12'h999, 24'h909090, 1'b0);
    wait_done(2, 12, "w10_999");
    repeat (2) @(posedge clk);
    #1;
    issue2(10'd5);
    push2(12'h005, 24'hFFFF92, 1'b0);
    wait_done(2, 12, "w10_5");

    repeat (3) @(posedge clk);
    #1;
    chk("q_drained", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
